// File: rtl/tlb_lookup_if.sv
// Translate request/response channel between the load/store stage and the TLB.
// master = CPU side, slave = TLB side.
interface tlb_lookup_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_store;
  logic [7:0]  cur_asid;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic        resp_miss;
  logic        resp_invalid;
  logic        resp_modified;

  modport master (
    output req_valid, req_vaddr, req_store, cur_asid, resp_ready,
    input  req_ready, resp_valid, resp_paddr, resp_miss, resp_invalid, resp_modified
  );

  modport slave (
    input  req_valid, req_vaddr, req_store, cur_asid, resp_ready,
    output req_ready, resp_valid, resp_paddr, resp_miss, resp_invalid, resp_modified
  );
endinterface

// File: rtl/tlb_lookup.sv
// Joint TLB array: one-cycle translation, serial TLBP probe and indexed TLBR read.
// Optional macro TLB_STATS_EN enables the saturating miss_count statistic.
module tlb_lookup #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             res,
  tlb_lookup_if.slave      tif,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [31:0]      wr_hi,
  input  logic [31:0]      wr_lo0,
  input  logic [31:0]      wr_lo1,
  input  logic             probe_start,
  input  logic [31:0]      probe_hi,
  output logic             probe_busy,
  output logic             probe_done,
  output logic             probe_hit,
  output logic [IDX_W-1:0] probe_index,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_index,
  output logic [31:0]      rd_hi,
  output logic [31:0]      rd_lo0,
  output logic [31:0]      rd_lo1,
  output logic [31:0]      miss_count
);

  typedef enum logic [1:0] {P_IDLE, P_SCAN, P_DONE} probe_state_t;

  logic [31:0] hi_mem  [ENTRIES];
  logic [31:0] lo0_mem [ENTRIES];
  logic [31:0] lo1_mem [ENTRIES];

  // Keys share the EntryHi layout so both translate and probe use one comparator.
  function automatic logic entry_match(input logic [31:0] e_hi, input logic g0,
                                       input logic g1, input logic [31:0] key);
    logic [31:0] diff;
    diff = e_hi ^ key;
    return ((diff & 32'hffffe000) == 32'h0) &&
           ((g0 & g1) || ((diff & 32'h000000ff) == 32'h0));
  endfunction

  logic [31:0]      lookup_key;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [31:0]      sel_lo;
  logic             unmapped;
  logic             accept;
  logic [31:0]      nxt_paddr;
  logic             nxt_miss, nxt_invalid, nxt_modified;

  assign lookup_key   = {tif.req_vaddr[31:13], 5'b0, tif.cur_asid};
  assign unmapped     = (tif.req_vaddr[31:30] == 2'b10);
  assign tif.req_ready = !tif.resp_valid || tif.resp_ready;
  assign accept       = tif.req_valid && tif.req_ready;

  // Scan from the top down so the lowest matching index is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entry_match(hi_mem[i], lo0_mem[i][0], lo1_mem[i][0], lookup_key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel_lo = tif.req_vaddr[12] ? lo1_mem[hit_idx] : lo0_mem[hit_idx];

  always_comb begin
    nxt_paddr    = 32'h0;
    nxt_miss     = 1'b0;
    nxt_invalid  = 1'b0;
    nxt_modified = 1'b0;
    if (unmapped)
      nxt_paddr = tif.req_vaddr & 32'h1fffffff;
    else if (!hit)
      nxt_miss = 1'b1;
    else if (!sel_lo[1])
      nxt_invalid = 1'b1;
    else if (tif.req_store && !sel_lo[2])
      nxt_modified = 1'b1;
    else
      nxt_paddr = {sel_lo[25:6], tif.req_vaddr[11:0]};
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      tif.resp_valid    <= 1'b0;
      tif.resp_paddr    <= 32'h0;
      tif.resp_miss     <= 1'b0;
      tif.resp_invalid  <= 1'b0;
      tif.resp_modified <= 1'b0;
    end else if (accept) begin
      tif.resp_valid    <= 1'b1;
      tif.resp_paddr    <= nxt_paddr;
      tif.resp_miss     <= nxt_miss;
      tif.resp_invalid  <= nxt_invalid;
      tif.resp_modified <= nxt_modified;
    end else if (tif.resp_ready) begin
      tif.resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < ENTRIES; i++) begin
        hi_mem[i]  <= 32'h0;
        lo0_mem[i] <= 32'h0;
        lo1_mem[i] <= 32'h0;
      end
    end else if (wr_en) begin
      hi_mem[wr_index]  <= wr_hi & 32'hffffe0ff;
      lo0_mem[wr_index] <= wr_lo0;
      lo1_mem[wr_index] <= wr_lo1;
    end
  end

  probe_state_t     pstate;
  logic [IDX_W-1:0] cnt;
  logic [31:0]      probe_key;

  // Any entry write during a scan may change the answer, so the scan starts over.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pstate      <= P_IDLE;
      cnt         <= '0;
      probe_key   <= 32'h0;
      probe_busy  <= 1'b0;
      probe_done  <= 1'b0;
      probe_hit   <= 1'b0;
      probe_index <= '0;
    end else begin
      probe_done <= 1'b0;
      case (pstate)
        P_IDLE: begin
          if (probe_start) begin
            probe_key   <= probe_hi;
            cnt         <= '0;
            probe_busy  <= 1'b1;
            probe_hit   <= 1'b0;
            probe_index <= '0;
            pstate      <= P_SCAN;
          end
        end
        P_SCAN: begin
          if (wr_en) begin
            cnt <= '0;
          end else if (entry_match(hi_mem[cnt], lo0_mem[cnt][0], lo1_mem[cnt][0], probe_key)) begin
            probe_hit   <= 1'b1;
            probe_index <= cnt;
            pstate      <= P_DONE;
          end else if (cnt == IDX_W'(ENTRIES - 1)) begin
            probe_hit   <= 1'b0;
            probe_index <= '0;
            pstate      <= P_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        P_DONE: begin
          probe_done <= 1'b1;
          probe_busy <= 1'b0;
          pstate     <= P_IDLE;
        end
        default: pstate <= P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rd_hi  <= 32'h0;
      rd_lo0 <= 32'h0;
      rd_lo1 <= 32'h0;
    end else if (rd_en) begin
      rd_hi  <= hi_mem[rd_index];
      rd_lo0 <= lo0_mem[rd_index];
      rd_lo1 <= lo1_mem[rd_index];
    end
  end

`ifdef TLB_STATS_EN
  logic [31:0] miss_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res)
      miss_q <= 32'h0;
    else if (accept && nxt_miss && (miss_q != 32'hffffffff))
      miss_q <= miss_q + 32'h1;
  end

  assign miss_count = miss_q;
`else
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_tlb_lookup.sv
// Scoreboard bench for tlb_lookup: directed translations, backpressure, probes,
// TLBR reads and asynchronous reset; miss_count expectation follows TLB_STATS_EN.
module tb_tlb_lookup;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  tlb_lookup_if tif();

  logic             wr_en;
  logic [IDX_W-1:0] wr_index;
  logic [31:0]      wr_hi, wr_lo0, wr_lo1;
  logic             probe_start;
  logic [31:0]      probe_hi;
  logic             probe_busy, probe_done, probe_hit;
  logic [IDX_W-1:0] probe_index;
  logic             rd_en;
  logic [IDX_W-1:0] rd_index;
  logic [31:0]      rd_hi, rd_lo0, rd_lo1, miss_count;

  tlb_lookup #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .res(res), .tif(tif),
    .wr_en(wr_en), .wr_index(wr_index), .wr_hi(wr_hi), .wr_lo0(wr_lo0), .wr_lo1(wr_lo1),
    .probe_start(probe_start), .probe_hi(probe_hi), .probe_busy(probe_busy),
    .probe_done(probe_done), .probe_hit(probe_hit), .probe_index(probe_index),
    .rd_en(rd_en), .rd_index(rd_index), .rd_hi(rd_hi), .rd_lo0(rd_lo0), .rd_lo1(rd_lo1),
    .miss_count(miss_count)
  );

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        inv;
    logic        modf;
  } resp_t;

  resp_t expQ[$];
  int checks  = 0;
  int errors  = 0;
  int expMiss = 0;
  int w;
  int n;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed response handshake is compared against the queue head.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (res === 1'b1 && tif.resp_valid && tif.resp_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got paddr %h, expected no response", tif.resp_paddr);
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_paddr", tif.resp_paddr, e.paddr);
          checkOutput("resp_miss", {31'b0, tif.resp_miss}, {31'b0, e.miss});
          checkOutput("resp_invalid", {31'b0, tif.resp_invalid}, {31'b0, e.inv});
          checkOutput("resp_modified", {31'b0, tif.resp_modified}, {31'b0, e.modf});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [31:0] vaddr, input logic store, input logic [7:0] asid,
                               input logic [31:0] ePaddr, input logic eMiss, input logic eInv,
                               input logic eMod, output int waits);
    resp_t e;
    bit ok;
    tif.req_valid = 1'b1;
    tif.req_vaddr = vaddr;
    tif.req_store = store;
    tif.cur_asid  = asid;
    ok    = 1'b0;
    waits = 0;
    while (!ok && waits < 20) begin
      @(negedge clk);
      if (tif.req_ready) begin
        ok = 1'b1;
        e.paddr = ePaddr;
        e.miss  = eMiss;
        e.inv   = eInv;
        e.modf  = eMod;
        expQ.push_back(e);
        if (eMiss) expMiss++;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_accept: got no accept, expected accept within 20 cycles");
    end
  endtask

  task automatic writeEntry(input logic [IDX_W-1:0] idx, input logic [31:0] hi,
                            input logic [31:0] lo0, input logic [31:0] lo1);
    wr_index = idx;
    wr_hi    = hi;
    wr_lo0   = lo0;
    wr_lo1   = lo1;
    wr_en    = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic runProbe(input logic [31:0] hi, input int wrAt, output int cycles);
    probe_hi    = hi;
    probe_start = 1'b1;
    @(posedge clk);
    #1;
    probe_start = 1'b0;
    cycles = 0;
    while (!probe_done && cycles < 40) begin
      if (cycles == 2) checkOutput("probe_busy_scan", {31'b0, probe_busy}, 32'd1);
      if (cycles == wrAt) begin
        wr_index = 4'd15;
        wr_hi    = 32'h0;
        wr_lo0   = 32'h0;
        wr_lo1   = 32'h0;
        wr_en    = 1'b1;
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      cycles++;
    end
  endtask

  task automatic idleCycles(input int k);
    tif.req_valid = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    res = 1'b0;
    tif.req_valid = 1'b0; tif.req_vaddr = 32'h0; tif.req_store = 1'b0;
    tif.cur_asid = 8'h0;  tif.resp_ready = 1'b1;
    wr_en = 1'b0; wr_index = '0; wr_hi = 32'h0; wr_lo0 = 32'h0; wr_lo1 = 32'h0;
    probe_start = 1'b0; probe_hi = 32'h0; rd_en = 1'b0; rd_index = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_resp_valid", {31'b0, tif.resp_valid}, 32'd0);
    checkOutput("rst_resp_paddr", tif.resp_paddr, 32'd0);
    checkOutput("rst_req_ready", {31'b0, tif.req_ready}, 32'd1);
    checkOutput("rst_probe_busy", {31'b0, probe_busy}, 32'd0);
    checkOutput("rst_probe_done", {31'b0, probe_done}, 32'd0);
    checkOutput("rst_rd_hi", rd_hi, 32'd0);
    checkOutput("rst_miss_count", miss_count, 32'd0);
    res = 1'b1;
    @(posedge clk);
    #1;

    // EntryHi bits 12:8 must be dropped on store
    writeEntry(4'd3, 32'h00401f55, 32'h00001006, 32'h0);
    rd_index = 4'd3;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    checkOutput("rd_hi", rd_hi, 32'h00400055);
    checkOutput("rd_lo0", rd_lo0, 32'h00001006);
    checkOutput("rd_lo1", rd_lo1, 32'h0);

    applyStimulus(32'h00400abc, 1'b0, 8'h55, 32'h00040abc, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(32'h00401abc, 1'b0, 8'h55, 32'h0,        1'b0, 1'b1, 1'b0, w);
    applyStimulus(32'h00400abc, 1'b1, 8'h55, 32'h00040abc, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(32'h00400abc, 1'b0, 8'h56, 32'h0,        1'b1, 1'b0, 1'b0, w);
    applyStimulus(32'ha0001234, 1'b0, 8'h56, 32'h00001234, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(32'h80400abc, 1'b1, 8'h00, 32'h00400abc, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(32'hc0400abc, 1'b0, 8'h55, 32'h0,        1'b1, 1'b0, 1'b0, w);
    idleCycles(1);

    writeEntry(4'd3, 32'h00400055, 32'h00001002, 32'h0);
    applyStimulus(32'h00400abc, 1'b1, 8'h55, 32'h0,        1'b0, 1'b0, 1'b1, w);
    applyStimulus(32'h00400abc, 1'b0, 8'h55, 32'h00040abc, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(32'h00401abc, 1'b1, 8'h55, 32'h0,        1'b0, 1'b1, 1'b0, w);
    idleCycles(1);

    writeEntry(4'd3, 32'h00400055, 32'h00001007, 32'h00000001);
    applyStimulus(32'h00400abc, 1'b0, 8'h56, 32'h00040abc, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(32'h00401abc, 1'b0, 8'h99, 32'h0,        1'b0, 1'b1, 1'b0, w);
    idleCycles(1);

    // Index 1 overlaps index 3; lowest index must win, and a same-edge write is not seen
    writeEntry(4'd1, 32'h00400055, 32'h00001dc6, 32'h0);
    applyStimulus(32'h00400abc, 1'b0, 8'h55, 32'h00077abc, 1'b0, 1'b0, 1'b0, w);
    wr_index = 4'd1; wr_hi = 32'h0; wr_lo0 = 32'h0; wr_lo1 = 32'h0; wr_en = 1'b1;
    applyStimulus(32'h00400abc, 1'b0, 8'h55, 32'h00077abc, 1'b0, 1'b0, 1'b0, w);
    wr_en = 1'b0;
    applyStimulus(32'h00400abc, 1'b0, 8'h55, 32'h00040abc, 1'b0, 1'b0, 1'b0, w);
    applyStimulus(32'h70000000, 1'b0, 8'h12, 32'h0,        1'b1, 1'b0, 1'b0, w);
    applyStimulus(32'h12345678, 1'b1, 8'h01, 32'h0,        1'b1, 1'b0, 1'b0, w);
    applyStimulus(32'h00600000, 1'b0, 8'h55, 32'h0,        1'b1, 1'b0, 1'b0, w);
    idleCycles(3);

    // Backpressure: result must hold and no new request may be taken
    tif.resp_ready = 1'b0;
    applyStimulus(32'h00400abc, 1'b0, 8'h55, 32'h00040abc, 1'b0, 1'b0, 1'b0, w);
    tif.req_vaddr = 32'ha0000010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_req_ready", {31'b0, tif.req_ready}, 32'd0);
      checkOutput("bp_resp_valid", {31'b0, tif.resp_valid}, 32'd1);
      checkOutput("bp_resp_paddr", tif.resp_paddr, 32'h00040abc);
      @(posedge clk);
      #1;
    end
    tif.resp_ready = 1'b1;
    applyStimulus(32'ha0000010, 1'b0, 8'h55, 32'h00000010, 1'b0, 1'b0, 1'b0, w);
    checkOutput("bp_release_wait", w, 32'd0);
    idleCycles(3);

`ifdef TLB_STATS_EN
    checkOutput("miss_count", miss_count, expMiss);
`else
    checkOutput("miss_count", miss_count, 32'd0);
`endif

    writeEntry(4'd9, 32'h12340033, 32'h00000002, 32'h00000002);
    runProbe(32'h12340033, -1, n);
    checkOutput("probe9_latency", n, 32'd11);
    checkOutput("probe9_hit", {31'b0, probe_hit}, 32'd1);
    checkOutput("probe9_index", {28'b0, probe_index}, 32'd9);
    @(posedge clk);
    #1;
    checkOutput("probe_done_pulse", {31'b0, probe_done}, 32'd0);
    checkOutput("probe_hit_hold", {31'b0, probe_hit}, 32'd1);

    runProbe(32'h55550011, -1, n);
    checkOutput("probe_absent_latency", n, 32'd17);
    checkOutput("probe_absent_hit", {31'b0, probe_hit}, 32'd0);
    checkOutput("probe_absent_index", {28'b0, probe_index}, 32'd0);

    runProbe(32'h12340033, 4, n);
    checkOutput("probe_restart_latency", n, 32'd16);
    checkOutput("probe_restart_index", {28'b0, probe_index}, 32'd9);

    runProbe(32'h00400077, -1, n);
    checkOutput("probe_global_latency", n, 32'd5);
    checkOutput("probe_global_index", {28'b0, probe_index}, 32'd3);

    // Reset in the middle of a scan
    probe_hi = 32'h55550011;
    probe_start = 1'b1;
    @(posedge clk);
    #1;
    probe_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_rst_busy", {31'b0, probe_busy}, 32'd1);
    res = 1'b0;
    #1;
    checkOutput("arst_probe_busy", {31'b0, probe_busy}, 32'd0);
    checkOutput("arst_probe_index", {28'b0, probe_index}, 32'd0);
    checkOutput("arst_resp_paddr", tif.resp_paddr, 32'd0);
    checkOutput("arst_rd_hi", rd_hi, 32'd0);
    checkOutput("arst_miss_count", miss_count, 32'd0);
    expMiss = 0;
    @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_probe_done", {31'b0, probe_done}, 32'd0);
    applyStimulus(32'h00400abc, 1'b0, 8'h55, 32'h0, 1'b1, 1'b0, 1'b0, w);
    rd_index = 4'd9;
    rd_en = 1'b1;
    idleCycles(1);
    rd_en = 1'b0;
    checkOutput("post_rst_rd_hi", rd_hi, 32'd0);
    idleCycles(2);
`ifdef TLB_STATS_EN
    checkOutput("post_rst_miss_count", miss_count, expMiss);
`else
    checkOutput("post_rst_miss_count", miss_count, 32'd0);
`endif

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL resp_drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
